// File: rtl/postadd_seq.sv
// postadd_seq
//   Sequences postadder operations onto a small bank of accumulators and keeps
//   each accumulator's carry headroom in check. Every accumulator tracks how
//   many accumulating ops it has absorbed. An op that would exceed the carry
//   budget first triggers a normalising flush. The flush reads the
//   accumulator out through L3touint, waits for the result, and reloads it
//   from the L3touint output. Only then is the deferred op issued.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   cmd_op       000 hold, 001 load, 010 add, 011 din-acc, 100 acc-din,
//                101 Mod-acc, 110/111 illegal
//   cmd_acc      target accumulator
//   cmd_last     read the result out after this op
//   issue_valid  postadder op issued this cycle
//   mode3        postadder mode
//   addr3        postadder accumulator address
//   outsel       2'b10 readout to L3touint, 2'b00 idle
//   in_sel       0 external operand, 1 L3touint result
//   res_valid    L3touint output holds a requested result
//   res_acc      accumulator that res_valid refers to
//   err_illegal  one-cycle pulse when an illegal op is accepted

module postadd_seq #(
    parameter int N_ACC        = 4,
    parameter int CARRY_BUDGET = 128,
    parameter int PIPE_LAT     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_acc,
    input  logic       cmd_last,
    output logic       issue_valid,
    output logic [2:0] mode3,
    output logic [1:0] addr3,
    output logic [1:0] outsel,
    output logic       in_sel,
    output logic       res_valid,
    output logic [1:0] res_acc,
    output logic       err_illegal
);

    localparam int unsigned NA = N_ACC;
    localparam int unsigned PL = PIPE_LAT;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_MAX  = 3'b101;

    localparam logic [1:0] SEL_READ = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b00;

    localparam logic [8:0] BUDGET    = 9'(CARRY_BUDGET);
    localparam logic [7:0] WAIT_LAST = 8'(PIPE_LAT - 2);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH_RD,
        FLUSH_WAIT,
        FLUSH_LD,
        ISSUE_PEND
    } state_t;

    state_t state, nxt_state;

    // Registered issue bundle; each state's issue is prepared one cycle early
    // so that the bundle is on the outputs during the cycle named by the state.
    logic       ready_q, n_ready;
    logic       iv_q, n_iv;
    logic [2:0] mode_q, n_mode;
    logic [1:0] addr_q, n_addr;
    logic [1:0] outsel_q, n_outsel;
    logic       insel_q, n_insel;
    logic       rdreq_q, n_rdreq;   // readout requested by cmd_last (not a flush)
    logic       err_q, n_err;

    logic [2:0] pend_op;
    logic [1:0] pend_acc;
    logic       pend_last;
    logic       pend_ld;

    logic [7:0] wait_cnt, nxt_wait;

    logic [7:0] counts [NA];
    logic       cnt_we;
    logic [1:0] cnt_idx;
    logic [7:0] cnt_val;

    logic [PL-1:0] rp_v;
    logic [1:0]    rp_acc [PL];

    logic       accept;
    logic       legal;
    logic       incr_op;
    logic [8:0] cnt_inc;
    logic       over;

    assign accept  = cmd_valid && ready_q;
    assign legal   = (cmd_op <= OP_MAX);
    assign incr_op = legal && (cmd_op != OP_HOLD) && (cmd_op != OP_LOAD);
    assign cnt_inc = {1'b0, counts[cmd_acc]} + 9'd1;
    assign over    = incr_op && (cnt_inc > BUDGET);

    always_comb begin
        nxt_state = state;
        n_iv      = 1'b0;
        n_mode    = '0;
        n_addr    = '0;
        n_outsel  = SEL_NONE;
        n_insel   = 1'b0;
        n_rdreq   = 1'b0;
        n_err     = 1'b0;
        pend_ld   = 1'b0;
        nxt_wait  = '0;
        cnt_we    = 1'b0;
        cnt_idx   = '0;
        cnt_val   = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        n_err = 1'b1;
                    end else if (over) begin
                        pend_ld   = 1'b1;
                        nxt_state = FLUSH_RD;
                        n_iv      = 1'b1;
                        n_mode    = OP_HOLD;
                        n_addr    = cmd_acc;
                        n_outsel  = SEL_READ;
                    end else begin
                        n_iv     = 1'b1;
                        n_mode   = cmd_op;
                        n_addr   = cmd_acc;
                        n_outsel = cmd_last ? SEL_READ : SEL_NONE;
                        n_rdreq  = cmd_last;
                        if (cmd_op == OP_LOAD) begin
                            cnt_we  = 1'b1;
                            cnt_idx = cmd_acc;
                            cnt_val = 8'd1;
                        end else if (incr_op) begin
                            cnt_we  = 1'b1;
                            cnt_idx = cmd_acc;
                            cnt_val = cnt_inc[7:0];
                        end
                    end
                end
            end

            FLUSH_RD: begin
                nxt_state = FLUSH_WAIT;
            end

            FLUSH_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    // Result of the flush readout is now on L3touint: reload it.
                    nxt_state = FLUSH_LD;
                    n_iv      = 1'b1;
                    n_mode    = OP_LOAD;
                    n_addr    = pend_acc;
                    n_insel   = 1'b1;
                end else begin
                    nxt_wait = wait_cnt + 8'd1;
                end
            end

            FLUSH_LD: begin
                cnt_we    = 1'b1;
                cnt_idx   = pend_acc;
                cnt_val   = 8'd1;
                nxt_state = ISSUE_PEND;
                n_iv      = 1'b1;
                n_mode    = pend_op;
                n_addr    = pend_acc;
                n_outsel  = pend_last ? SEL_READ : SEL_NONE;
                n_rdreq   = pend_last;
            end

            ISSUE_PEND: begin
                cnt_we    = 1'b1;
                cnt_idx   = pend_acc;
                cnt_val   = counts[pend_acc] + 8'd1;
                nxt_state = IDLE;
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase

        n_ready = (nxt_state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            iv_q      <= 1'b0;
            mode_q    <= '0;
            addr_q    <= '0;
            outsel_q  <= '0;
            insel_q   <= 1'b0;
            rdreq_q   <= 1'b0;
            err_q     <= 1'b0;
            pend_op   <= '0;
            pend_acc  <= '0;
            pend_last <= 1'b0;
            wait_cnt  <= '0;
            for (int unsigned i = 0; i < NA; i++) begin
                counts[i] <= '0;
            end
            rp_v <= '0;
            for (int unsigned i = 0; i < PL; i++) begin
                rp_acc[i] <= '0;
            end
        end else begin
            state    <= nxt_state;
            ready_q  <= n_ready;
            iv_q     <= n_iv;
            mode_q   <= n_mode;
            addr_q   <= n_addr;
            outsel_q <= n_outsel;
            insel_q  <= n_insel;
            rdreq_q  <= n_rdreq;
            err_q    <= n_err;
            wait_cnt <= nxt_wait;
            if (pend_ld) begin
                pend_op   <= cmd_op;
                pend_acc  <= cmd_acc;
                pend_last <= cmd_last;
            end
            if (cnt_we) begin
                counts[cnt_idx] <= cnt_val;
            end
            // Stage 0 loads one cycle after the issue, so the last stage lines
            // up PIPE_LAT cycles after it.
            rp_v[0]   <= rdreq_q;
            rp_acc[0] <= rdreq_q ? addr_q : 2'b00;
            for (int unsigned i = 1; i < PL; i++) begin
                rp_v[i]   <= rp_v[i-1];
                rp_acc[i] <= rp_acc[i-1];
            end
        end
    end

    assign cmd_ready   = ready_q;
    assign issue_valid = iv_q;
    assign mode3       = mode_q;
    assign addr3       = addr_q;
    assign outsel      = outsel_q;
    assign in_sel      = insel_q;
    assign err_illegal = err_q;
    assign res_valid   = rp_v[PL-1];
    assign res_acc     = rp_acc[PL-1];

endmodule
